// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: COLS_PER_CYCLE columns per clock behind a valid/ready handshake.
// Optional build macro MIXCOL_FWD_SUPPORT_EN adds in_fwd to select forward MixColumns per operation.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef MIXCOL_FWD_SUPPORT_EN
    input  logic         in_fwd,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    // For COLS_PER_CYCLE=4 both constants truncate to 0, giving a single BUSY cycle.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            cols_per_cycle_must_be_1_2_or_4 u_bad_cols ();
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [1:0] col_idx_r;
    logic       in_ready_r;
    logic       out_valid_r;
    logic [7:0] work_r        [16];
    logic [7:0] result_r      [16];
    logic [7:0] next_result_s [16];
    logic [7:0] in_bytes_s    [16];
`ifdef MIXCOL_FWD_SUPPORT_EN
    logic       fwd_r;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients are at most 4 bits wide, so three chained xtime stages cover every product.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] coef);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{coef[0]}} & b) ^ ({8{coef[1]}} & x2) ^ ({8{coef[2]}} & x4) ^ ({8{coef[3]}} & x8);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        {a, b, c, d} = col;
        return {gf_mul(a, 4'he) ^ gf_mul(b, 4'hb) ^ gf_mul(c, 4'hd) ^ gf_mul(d, 4'h9),
                gf_mul(a, 4'h9) ^ gf_mul(b, 4'he) ^ gf_mul(c, 4'hb) ^ gf_mul(d, 4'hd),
                gf_mul(a, 4'hd) ^ gf_mul(b, 4'h9) ^ gf_mul(c, 4'he) ^ gf_mul(d, 4'hb),
                gf_mul(a, 4'hb) ^ gf_mul(b, 4'hd) ^ gf_mul(c, 4'h9) ^ gf_mul(d, 4'he)};
    endfunction

`ifdef MIXCOL_FWD_SUPPORT_EN
    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        {a, b, c, d} = col;
        return {gf_mul(a, 4'h2) ^ gf_mul(b, 4'h3) ^ c ^ d,
                a ^ gf_mul(b, 4'h2) ^ gf_mul(c, 4'h3) ^ d,
                a ^ b ^ gf_mul(c, 4'h2) ^ gf_mul(d, 4'h3),
                gf_mul(a, 4'h3) ^ b ^ c ^ gf_mul(d, 4'h2)};
    endfunction
`endif

    generate
        for (genvar k = 0; k < 16; k++) begin : g_bytes
            assign in_bytes_s[k]            = in_state[127 - 8*k -: 8];
            assign out_state[127 - 8*k -: 8] = result_r[k];
        end
    endgenerate

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;

    // Transform the columns scheduled for this cycle on top of the current result bytes
    always_comb begin
        logic [1:0]  col;
        logic [31:0] col_in;
        logic [31:0] col_out;
        col           = 2'd0;
        col_in        = 32'h0000_0000;
        col_out       = 32'h0000_0000;
        next_result_s = result_r;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col    = col_idx_r + 2'(j);
            col_in = {work_r[{2'd0, col}], work_r[{2'd1, col}], work_r[{2'd2, col}], work_r[{2'd3, col}]};
`ifdef MIXCOL_FWD_SUPPORT_EN
            if (fwd_r) begin
                col_out = fwd_col(col_in);
            end else begin
                col_out = inv_col(col_in);
            end
`else
            col_out = inv_col(col_in);
`endif
            next_result_s[{2'd0, col}] = col_out[31:24];
            next_result_s[{2'd1, col}] = col_out[23:16];
            next_result_s[{2'd2, col}] = col_out[15:8];
            next_result_s[{2'd3, col}] = col_out[7:0];
        end
    end

    // Control FSM with work/result registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            col_idx_r   <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            work_r      <= '{default: 8'h00};
            result_r    <= '{default: 8'h00};
`ifdef MIXCOL_FWD_SUPPORT_EN
            fwd_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        work_r     <= in_bytes_s;
                        col_idx_r  <= 2'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
`ifdef MIXCOL_FWD_SUPPORT_EN
                        fwd_r      <= in_fwd;
`endif
                    end
                end
                BUSY: begin
                    result_r  <= next_result_s;
                    col_idx_r <= col_idx_r + COL_STEP;
                    if (col_idx_r == LAST_COL) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    col_idx_r   <= 2'd0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed vectors, backpressure, mid-operation reset
// and a random stream compared against a byte-matrix GF(2^8) reference model.
module tb_inv_mix_columns_seq;
    parameter int CPC = 1;
    localparam int NCYC = 4 / CPC;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef MIXCOL_FWD_SUPPORT_EN
    logic         in_fwd;
`endif

    int           errors = 0;
    int           checks = 0;
    logic [127:0] last_out;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef MIXCOL_FWD_SUPPORT_EN
        .in_fwd    (in_fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, reduction polynomial 0x11b
    function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product on the 4x4 state, s[r][c] = byte 4r+c
    function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit fwd);
        logic [7:0]   m  [4];
        logic [7:0]   st [16];
        logic [7:0]   o  [16];
        logic [7:0]   acc;
        logic [127:0] r;
        if (fwd) m = '{8'h02, 8'h03, 8'h01, 8'h01};
        else     m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int k = 0; k < 16; k++) st[k] = s[127 - 8*k -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul_ref(m[(k - rr + 4) % 4], st[4*k + c]);
                o[4*rr + c] = acc;
            end
        end
        r = '0;
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = o[k];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one state, wait for acceptance and completion, check latency and data
    task automatic run_block(input logic [127:0] st, input bit fwd, input string tag);
        int           cyc;
        logic [127:0] exp;
        exp      = mix_ref(st, fwd);
        in_state = st;
        in_valid = 1'b1;
`ifdef MIXCOL_FWD_SUPPORT_EN
        in_fwd   = fwd;
`endif
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " ready"}, 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 128'(cyc), 128'(NCYC));
        check({tag, " data"}, out_state, exp);
        last_out = out_state;
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, " valid drop"}, 128'(out_valid), 128'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] held;
        logic [127:0] x;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
`ifdef MIXCOL_FWD_SUPPORT_EN
        in_fwd    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset out_state", out_state, 128'd0);
        rst = 1'b0;

        // Known InvMixColumns vectors
        run_block(128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 1'b0, "vec1");
        check("vec1 const", last_out, 128'hdbdbdbdb_13131313_53535353_45454545);
        run_block(128'hd5d5d5d5_d5d5d5d5_d7d7d7d7_d6d6d6d6, 1'b0, "vec2");
        check("vec2 const", last_out, 128'hd4d4d4d4_d4d4d4d4_d4d4d4d4_d5d5d5d5);
        run_block({16{8'h01}}, 1'b0, "all01");
        check("all01 const", last_out, {16{8'h01}});
        run_block({16{8'hc6}}, 1'b0, "allc6");
        check("allc6 const", last_out, {16{8'hc6}});

        // Backpressure: result held, in_ready low, extra in_valid ignored
        out_ready = 1'b0;
        run_block(128'h0123456789abcdef_fedcba9876543210, 1'b0, "bp");
        held = mix_ref(128'h0123456789abcdef_fedcba9876543210, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = rand128();
            @(posedge clk); #1;
            check("bp valid held", 128'(out_valid), 128'd1);
            check("bp data held", out_state, held);
            check("bp in_ready low", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release valid", 128'(out_valid), 128'd0);
        check("bp release ready", 128'(in_ready), 128'd1);
        check("bp idle data", out_state, held);
        @(posedge clk); #1;
        check("bp no extra", 128'(out_valid), 128'd0);

        // Reset during the second BUSY cycle discards the partial result
        in_state = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst in_ready", 128'(in_ready), 128'd1);
        check("midrst out_valid", 128'(out_valid), 128'd0);
        check("midrst out_state", out_state, 128'd0);
        run_block(rand128(), 1'b0, "post rst");

        // Random stream, offered back to back
        for (int i = 0; i < 20; i++) run_block(rand128(), 1'b0, "stream");

`ifdef MIXCOL_FWD_SUPPORT_EN
        run_block(128'hdbdbdbdb_13131313_53535353_45454545, 1'b1, "fwd vec");
        check("fwd vec const", last_out, 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc);
        for (int i = 0; i < 8; i++) begin
            x = rand128();
            run_block(x, 1'b1, "rt fwd");
            run_block(last_out, 1'b0, "rt inv");
            check("round trip", last_out, x);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
